// File: rtl/spi_daisy_seq.sv
// Upstream sequencer for the SPI daisy chain: TX FIFO, one newd frame per byte, RX capture.
// Optional echo compare (err/err_cnt) is built when SPI_SEQ_ECHO_CHK_EN is defined.
module spi_daisy_seq #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NEWD_CLKS  = 8,
    parameter int unsigned FRAME_CLKS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    output logic                   s_ready,
    output logic                   m_valid,
    output logic [7:0]             m_data,
    input  logic                   m_ready,
    output logic                   newd,
    output logic [7:0]             din,
    input  logic [7:0]             dout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
`ifdef SPI_SEQ_ECHO_CHK_EN
    ,
    output logic                   err,
    output logic [7:0]             err_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(FRAME_CLKS + 1);

    localparam logic [2:0] ST_GUARD  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_ASSERT = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             newd_q, newd_d;
    logic [7:0]       din_q, din_d;
    logic [7:0]       cap_q, cap_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       mem_q [DEPTH];
    logic             push_c;
    logic             pop_c;

`ifdef SPI_SEQ_ECHO_CHK_EN
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
`endif

    assign s_ready = (level_q != LVL_W'(DEPTH));
    assign push_c  = s_valid && s_ready;

    // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two
    assign level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Frame sequencer next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        newd_d    = newd_q;
        din_d     = din_q;
        cap_d     = cap_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        pop_c     = 1'b0;
`ifdef SPI_SEQ_ECHO_CHK_EN
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            ST_GUARD: begin
                // Let any frame cut short by reset drain out of the chain
                if (cnt_q == CNT_W'(FRAME_CLKS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop_c   = 1'b1;
                    din_d   = mem_q[rd_ptr_q];
                    newd_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    cap_d   = 8'h00;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NEWD_CLKS)) begin
                    newd_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dout != 8'h00) begin
                    cap_d = dout;
                end
                if (cnt_q == CNT_W'(FRAME_CLKS)) begin
                    cnt_d     = '0;
                    m_data_d  = cap_q;
                    m_valid_d = 1'b1;
                    state_d   = ST_RESP;
`ifdef SPI_SEQ_ECHO_CHK_EN
                    if (cap_q != din_q) begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
`endif
                end
            end
            ST_RESP: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_GUARD;
            cnt_q     <= '0;
            newd_q    <= 1'b0;
            din_q     <= 8'h00;
            cap_q     <= 8'h00;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            newd_q    <= newd_d;
            din_q     <= din_d;
            cap_q     <= cap_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

`ifdef SPI_SEQ_ECHO_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`endif

    assign newd    = newd_q;
    assign din     = din_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign level   = level_q;
    assign busy    = (state_q != ST_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_spi_daisy_seq.sv
// Bench for spi_daisy_seq: source/sink/chain models feed queue-based expectations.
module tb_spi_daisy_seq;

    localparam int DEPTH      = 4;
    localparam int NEWD_CLKS  = 8;
    localparam int FRAME_CLKS = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       newd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic [2:0] level;
`ifdef SPI_SEQ_ECHO_CHK_EN
    logic       err;
    logic [7:0] err_cnt;
    int         err_pulses = 0;
`endif

    spi_daisy_seq #(
        .DEPTH(DEPTH), .NEWD_CLKS(NEWD_CLKS), .FRAME_CLKS(FRAME_CLKS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .newd(newd), .din(din), .dout(dout),
        .busy(busy), .level(level)
`ifdef SPI_SEQ_ECHO_CHK_EN
        , .err(err), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state shared with the source / sink / chain processes
    logic [7:0] to_send[$];
    logic [7:0] acc_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] expv_q[$];
    logic [7:0] got_q[$];
    int  acc_cyc = 0, newd_rise_cyc = 0, mv_rise_cyc = 0, ready_rise_cyc = 0;
    int  rise_cnt = 0, newd_len = 0, lvl_max = 0;
    bit  saw_full = 0;
    bit  sink_en = 1;
    int  chain_mode = 0;  // 0 echo, 1 random returns, 2 fixed 0x5A

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Source: offers the head of to_send, records accepted bytes in order
    initial begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || to_send.size() == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = to_send[0];
                if (s_ready) begin
                    acc_q.push_back(to_send.pop_front());
                    acc_cyc = cyc;
                end else begin
                    saw_full = 1;
                end
            end
            if (int'(level) > lvl_max) lvl_max = int'(level);
        end
    end

    // Sink: consumes responses while enabled
    initial begin
        bit mr_prev;
        bit mv_prev;
        mv_prev = 0;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            mr_prev = m_ready;
            m_ready = sink_en && !rst;
            if (m_ready && !mr_prev) ready_rise_cyc = cyc;
            if (m_valid && !mv_prev) mv_rise_cyc = cyc;
            mv_prev = m_valid;
            if (m_valid && m_ready) got_q.push_back(m_data);
        end
    end

    // Chain: returns up to two values late in each frame; expected = last nonzero value seen
    initial begin
        int age;
        int hi_len;
        bit newd_prev;
        logic [7:0] v1, v2;
        age = -1; hi_len = 0; newd_prev = 0; v1 = 0; v2 = 0;
        dout = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                age = -1;
                newd_prev = 0;
                dout = 8'h00;
            end else begin
                if (newd && !newd_prev) begin
                    age = 0;
                    hi_len = 0;
                    newd_rise_cyc = cyc;
                    rise_cnt++;
                    sent_q.push_back(din);
                    case (chain_mode)
                        1: begin
                            v1 = 8'($urandom);
                            v2 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                        end
                        2: begin v1 = 8'h5A; v2 = 8'h00; end
                        default: begin v1 = din; v2 = 8'h00; end
                    endcase
                    expv_q.push_back((v2 != 8'h00) ? v2 : v1);
                end else if (age >= 0) begin
                    age++;
                end
                if (newd) hi_len++;
                if (!newd && newd_prev) newd_len = hi_len;
                newd_prev = newd;
                if (age >= 100 && age < 110)      dout = v1;
                else if (age >= 150 && age < 160) dout = v2;
                else                              dout = 8'h00;
                if (age > 300) age = -1;
            end
        end
    end

`ifdef SPI_SEQ_ECHO_CHK_EN
    always @(negedge clk) if (err === 1'b1) err_pulses <= err_pulses + 1;
`endif

    task automatic wait_done(input int budget, input bit rnd_sink);
        int n;
        n = 0;
        while (!(to_send.size() == 0 && !s_valid && !busy && !m_valid &&
                 got_q.size() == expv_q.size()) && n < budget) begin
            if (rnd_sink) sink_en = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        sink_en = 1;
        chk("done_timeout", 32'(n < budget), 1);
    endtask

    task automatic wait_rise(input int budget);
        int n;
        int rc;
        n = 0;
        rc = rise_cnt;
        while (rise_cnt == rc && n < budget) begin
            tick();
            n++;
        end
        chk("rise_timeout", 32'(n < budget), 1);
    endtask

    task automatic compare_queues(input string tag);
        chk({tag, "_din_count"}, sent_q.size(), acc_q.size());
        for (int i = 0; i < sent_q.size() && i < acc_q.size(); i++)
            chk({tag, "_din_order"}, sent_q[i], acc_q[i]);
        chk({tag, "_resp_count"}, got_q.size(), expv_q.size());
        for (int i = 0; i < got_q.size() && i < expv_q.size(); i++)
            chk({tag, "_resp"}, got_q[i], expv_q[i]);
        acc_q.delete(); sent_q.delete(); expv_q.delete(); got_q.delete();
    endtask

    task automatic release_reset(output int rel_cyc);
        @(posedge clk);
        #2;
        rel_cyc = cyc;
        rst = 1'b0;
    endtask

    initial begin
        int rel;
        int rc;
        bit stable;
        logic [7:0] d0;
        logic [7:0] t2 [4];

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        chk("rst_newd", newd, 0);
        chk("rst_din", din, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_busy_guard", busy, 1);
        release_reset(rel);
        repeat (FRAME_CLKS + 4) tick();
        chk("idle_busy", busy, 0);

        // Single byte: newd width, latency, echo
        to_send.push_back(8'hA5);
        wait_done(FRAME_CLKS * 2, 0);
        chk("t1_newd_len", newd_len, NEWD_CLKS);
        chk("t1_din", sent_q.size() > 0 ? sent_q[0] : 8'hxx, 8'hA5);
        chk("t1_newd_lat", newd_rise_cyc - acc_cyc, 2);
        chk("t1_mvalid_lat", mv_rise_cyc - acc_cyc, FRAME_CLKS + 2);
        chk("t1_resp", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'hA5);
        compare_queues("t1");

        // Back-to-back burst while idle
        lvl_max = 0;
        t2[0] = 8'h3C; t2[1] = 8'h81; t2[2] = 8'h00; t2[3] = 8'hFF;
        for (int i = 0; i < 4; i++) to_send.push_back(t2[i]);
        wait_done(FRAME_CLKS * 6, 0);
        chk("t2_level_max", lvl_max, 3);
        for (int i = 0; i < 4; i++)
            chk("t2_resp_const", i < got_q.size() ? got_q[i] : 8'hxx, t2[i]);
        compare_queues("t2");

        // Overfill while a frame is in flight
        to_send.push_back(8'h42);
        wait_rise(40);
        repeat (20) tick();
        lvl_max = 0;
        saw_full = 0;
        for (int i = 0; i < 5; i++) to_send.push_back(8'(8'h50 + i));
        wait_done(FRAME_CLKS * 8, 0);
        chk("t3_level_max", lvl_max, DEPTH);
        chk("t3_saw_full", saw_full, 1);
        chk("t3_accepted", acc_q.size(), 6);
        compare_queues("t3");

        // Response backpressure
        sink_en = 0;
        to_send.push_back(8'h11);
        to_send.push_back(8'h22);
        begin
            int n;
            n = 0;
            while (!m_valid && n < FRAME_CLKS * 2) begin tick(); n++; end
            chk("t4_mvalid_timeout", 32'(n < FRAME_CLKS * 2), 1);
        end
        d0 = m_data;
        rc = rise_cnt;
        stable = 1;
        repeat (500) begin
            tick();
            if (m_valid !== 1'b1 || m_data !== d0) stable = 0;
        end
        chk("t4_hold_stable", stable, 1);
        chk("t4_first_data", d0, 8'h11);
        chk("t4_no_newd", rise_cnt, rc);
        sink_en = 1;
        wait_rise(20);
        chk("t4_relaunch_lat", newd_rise_cyc - ready_rise_cyc, 2);
        wait_done(FRAME_CLKS * 2, 0);
        compare_queues("t4");

        // Reset in the middle of a frame with bytes queued
        to_send.push_back(8'h10);
        to_send.push_back(8'h20);
        to_send.push_back(8'h30);
        wait_rise(40);
        repeat (30) tick();
        chk("t5_level_before", level, 2);
        rst = 1'b1;
        #1;
        chk("t5_newd_rst", newd, 0);
        chk("t5_level_rst", level, 0);
        chk("t5_mvalid_rst", m_valid, 0);
        to_send.delete(); acc_q.delete(); sent_q.delete(); expv_q.delete(); got_q.delete();
        repeat (3) @(posedge clk);
        to_send.push_back(8'h77);
        release_reset(rel);
        wait_rise(FRAME_CLKS + 40);
        chk("t5_guard_lat", newd_rise_cyc - rel, FRAME_CLKS + 1);
        wait_done(FRAME_CLKS * 2, 0);
        compare_queues("t5");

`ifdef SPI_SEQ_ECHO_CHK_EN
        // Echo mismatch then a clean frame
        rc = err_pulses;
        chain_mode = 2;
        to_send.push_back(8'hA5);
        wait_done(FRAME_CLKS * 2, 0);
        chk("t6_err_pulse", err_pulses - rc, 1);
        chk("t6_err_cnt", err_cnt, 1);
        compare_queues("t6a");
        chain_mode = 0;
        to_send.push_back(8'h3C);
        wait_done(FRAME_CLKS * 2, 0);
        chk("t6_no_pulse", err_pulses - rc, 1);
        chk("t6_err_cnt_hold", err_cnt, 1);
        compare_queues("t6b");
`endif

        // Randomized traffic, chain returns and sink stalls
        chain_mode = 1;
        for (int i = 0; i < 6; i++) to_send.push_back(8'($urandom));
        wait_done(FRAME_CLKS * 16, 1);
        for (int i = 0; i < 4; i++) begin
            to_send.push_back(8'($urandom));
            repeat ($urandom_range(0, 300)) tick();
        end
        wait_done(FRAME_CLKS * 16, 1);
        compare_queues("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
